// File: rtl/ide_ctrl.sv
`default_nettype none
// ============================================================================
// ide_ctrl : single-transaction ATA/IDE PIO register-access engine
//            (one timed DIOR-/DIOW- bus cycle per request).
// Revision : 1.0 - initial release
// ============================================================================
module ide_ctrl #(
    parameter int unsigned T_SETUP = 3,
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_HOLD  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ata_rd,
    input  logic        ata_wr,
    input  logic [4:0]  ata_addr,
    input  logic [15:0] ata_in,
    output logic [15:0] ata_out,
    output logic        ata_done,
    inout  wire  [15:0] ide_data_bus,
    output logic        ide_dior,
    output logic        ide_diow,
    output logic [1:0]  ide_cs,
    output logic [2:0]  ide_da
);

    localparam int unsigned T_MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int unsigned T_MAX    = (T_MAX_SP > T_HOLD) ? T_MAX_SP : T_HOLD;
    localparam int          CNT_W    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [4:0]         addr, addr_nx;
    logic [15:0]        wdata, wdata_nx;
    logic [15:0]        rdata_nx;
    logic               is_wr, is_wr_nx;
    logic               bus_en;

    assign ide_data_bus = bus_en ? wdata : 16'hzzzz;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = addr;
        wdata_nx = wdata;
        is_wr_nx = is_wr;
        rdata_nx = ata_out;
        case (state)
            IDLE: begin
                if (ata_rd || ata_wr) begin
                    addr_nx  = ata_addr;
                    wdata_nx = ata_in;
                    is_wr_nx = ~ata_rd;   // read takes priority
                    cnt_nx   = CNT_W'(T_SETUP - 1);
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    cnt_nx   = CNT_W'(T_PULSE - 1);
                    state_nx = STROBE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    // Sample on the edge that releases DIOR-, while the drive still holds data.
                    if (!is_wr) rdata_nx = ide_data_bus;
                    cnt_nx   = CNT_W'(T_HOLD - 1);
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addr     <= '0;
            wdata    <= '0;
            is_wr    <= 1'b0;
            ata_out  <= '0;
            ata_done <= 1'b0;
            ide_cs   <= 2'b11;
            ide_da   <= 3'b000;
            ide_dior <= 1'b1;
            ide_diow <= 1'b1;
            bus_en   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            addr     <= addr_nx;
            wdata    <= wdata_nx;
            is_wr    <= is_wr_nx;
            ata_out  <= rdata_nx;
            ata_done <= (state_nx == DONE);
            ide_cs   <= (state_nx == IDLE) ? 2'b11  : addr_nx[4:3];
            ide_da   <= (state_nx == IDLE) ? 3'b000 : addr_nx[2:0];
            ide_dior <= !((state_nx == STROBE) && !is_wr_nx);
            ide_diow <= !((state_nx == STROBE) &&  is_wr_nx);
            bus_en   <= (state_nx != IDLE) && is_wr_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ide_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ide_ctrl : directed self-checking bench for ide_ctrl with a simple drive model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ide_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ata_rd = 1'b0;
    logic        ata_wr = 1'b0;
    logic [4:0]  ata_addr = '0;
    logic [15:0] ata_in = '0;
    logic [15:0] ata_out;
    logic        ata_done;
    wire  [15:0] ide_data_bus;
    logic        ide_dior;
    logic        ide_diow;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;
    logic [15:0] drv_val = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Drive model answers reads while DIOR- is low; an undriven bus floats high.
    assign ide_data_bus = (ide_dior == 1'b0) ? drv_val : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (ide_data_bus[i]);
    end

    ide_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ata_rd       (ata_rd),
        .ata_wr       (ata_wr),
        .ata_addr     (ata_addr),
        .ata_in       (ata_in),
        .ata_out      (ata_out),
        .ata_done     (ata_done),
        .ide_data_bus (ide_data_bus),
        .ide_dior     (ide_dior),
        .ide_diow     (ide_diow),
        .ide_cs       (ide_cs),
        .ide_da       (ide_da)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one request from a negedge; k counts negedges after the sampling edge E0.
    task automatic txn(input logic rd, input logic wr, input logic [4:0] a, input logic [15:0] d,
                       output int dior_lo, output int diow_lo, output int first_lo,
                       output int done_k, output int done_cnt, output logic [1:0] cs1,
                       output logic [2:0] da1, output logic bus_ok, output logic [15:0] bus31);
        dior_lo = 0; diow_lo = 0; first_lo = 0; done_k = 0; done_cnt = 0;
        cs1 = '0; da1 = '0; bus_ok = 1'b1; bus31 = '0;
        ata_rd = rd; ata_wr = wr; ata_addr = a; ata_in = d;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin cs1 = ide_cs; da1 = ide_da; end
            if (!ide_dior) dior_lo++;
            if (!ide_diow) diow_lo++;
            if ((!ide_dior || !ide_diow) && first_lo == 0) first_lo = k;
            if (k <= 30 && ide_data_bus !== d) bus_ok = 1'b0;
            if (k == 31) bus31 = ide_data_bus;
            if (ata_done) begin
                done_cnt++;
                done_k = k;
                ata_rd = 1'b0; ata_wr = 1'b0;
            end
        end
        ata_rd = 1'b0; ata_wr = 1'b0;
    endtask

    int          dlo, wlo, flo, dk, dc;
    logic [1:0]  cs1;
    logic [2:0]  da1;
    logic        bok;
    logic [15:0] b31;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", ide_cs, 2'b11);
        chk("rst_da", ide_da, 3'b000);
        chk("rst_dior", ide_dior, 1'b1);
        chk("rst_diow", ide_diow, 1'b1);
        chk("rst_done", ata_done, 1'b0);
        chk("rst_out", ata_out, 16'h0000);
        chk("rst_bus", ide_data_bus, 16'hFFFF);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Status read: strobe at k=4..13, done in cycle after edge E0+29 (k=30).
        drv_val = 16'h0050;
        txn(1'b1, 1'b0, 5'b10111, 16'h0000, dlo, wlo, flo, dk, dc, cs1, da1, bok, b31);
        chk("rd_cs", cs1, 2'b10);
        chk("rd_da", da1, 3'b111);
        chk("rd_dior_width", dlo, 10);
        chk("rd_first_low", flo, 4);
        chk("rd_diow", wlo, 0);
        chk("rd_done_k", dk, 30);
        chk("rd_done_cnt", dc, 1);
        chk("rd_out", ata_out, 16'h0050);

        // Data write.
        txn(1'b0, 1'b1, 5'b10000, 16'hA5C3, dlo, wlo, flo, dk, dc, cs1, da1, bok, b31);
        chk("wr_bus_driven", bok, 1'b1);
        chk("wr_bus_release", b31, 16'hFFFF);
        chk("wr_diow_width", wlo, 10);
        chk("wr_dior", dlo, 0);
        chk("wr_cs", cs1, 2'b10);
        chk("wr_da", da1, 3'b000);
        chk("wr_done_cnt", dc, 1);
        chk("wr_out_kept", ata_out, 16'h0050);

        // Device control write.
        txn(1'b0, 1'b1, 5'b01110, 16'h0002, dlo, wlo, flo, dk, dc, cs1, da1, bok, b31);
        chk("dc_cs", cs1, 2'b01);
        chk("dc_da", da1, 3'b110);
        chk("dc_done_cnt", dc, 1);
        chk("dc_bus_driven", bok, 1'b1);

        // Held poll: dones at k=30,61,92; DIOR- high from k=14 to next low at k=35.
        begin
            int pos[3];
            int n = 0;
            int rise_k = 0;
            int gap = 0;
            logic prev = 1'b1;
            drv_val = 16'h1234;
            ata_rd = 1'b1; ata_addr = 5'b10111;
            @(posedge clk);
            for (int k = 1; k <= 130; k++) begin
                @(negedge clk);
                if (prev && !ide_dior && rise_k > 0 && gap == 0) gap = k - rise_k;
                if (!prev && ide_dior) rise_k = k;
                prev = ide_dior;
                if (ata_done) begin
                    if (n < 3) pos[n] = k;
                    n++;
                    if (n == 3) ata_rd = 1'b0;
                end
            end
            ata_rd = 1'b0;
            chk("poll_count", n, 3);
            chk("poll_first", pos[0], 30);
            chk("poll_period1", pos[1] - pos[0], 31);
            chk("poll_period2", pos[2] - pos[1], 31);
            chk("poll_gap", gap, 21);
            chk("poll_out", ata_out, 16'h1234);
        end

        repeat (100) @(negedge clk);
        chk("hold_out", ata_out, 16'h1234);

        // Both requests high: the read wins.
        drv_val = 16'h0BAD;
        txn(1'b1, 1'b1, 5'b10000, 16'h5555, dlo, wlo, flo, dk, dc, cs1, da1, bok, b31);
        chk("prio_dior", dlo, 10);
        chk("prio_diow", wlo, 0);
        chk("prio_out", ata_out, 16'h0BAD);

        // Reset in the middle of a write strobe.
        begin
            int guard = 0;
            int dn = 0;
            ata_wr = 1'b1; ata_addr = 5'b10000; ata_in = 16'hA5C3;
            @(posedge clk);
            while (ide_diow && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("mr_strobe_seen", ide_diow, 1'b0);
            reset = 1'b1; ata_wr = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("mr_dior", ide_dior, 1'b1);
            chk("mr_diow", ide_diow, 1'b1);
            chk("mr_cs", ide_cs, 2'b11);
            chk("mr_bus", ide_data_bus, 16'hFFFF);
            chk("mr_out", ata_out, 16'h0000);
            chk("mr_done", ata_done, 1'b0);
            reset = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (ata_done) dn++;
            end
            chk("mr_no_done", dn, 0);
        end

        drv_val = 16'h0777;
        txn(1'b1, 1'b0, 5'b10111, 16'h0000, dlo, wlo, flo, dk, dc, cs1, da1, bok, b31);
        chk("post_done_k", dk, 30);
        chk("post_done_cnt", dc, 1);
        chk("post_out", ata_out, 16'h0777);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
